// File: rtl/apb_requester_if.sv
// Command/response port and APB3 bus bundled for the APB requester.
// The master modport is the requester's view; the slave modport is the
// view of whoever drives commands and models the APB completer.
interface apb_requester_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_requester.sv
// APB3 requester: turns one accepted valid/ready command into one APB
// transfer (SETUP, then ACCESS until PREADY or timeout) and returns a
// single-cycle response carrying read data, slave error and timeout status.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | PSEL high, PENABLE low, one cycle only
// ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
module apb_requester #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  apb_requester_if.master  bus
);

  // Counter only has to reach TIMEOUT-1; when TIMEOUT is 0 it just wraps.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             done;
  logic             tmo;

  assign bus.cmd_ready = (state_q == IDLE);

  // State register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode plus the accept/complete/abort strobes for the datapath.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.PREADY) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if ((TIMEOUT > 0) && (wait_cnt == CNT_LAST)) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered APB outputs, wait counter and response; PSEL/PENABLE are
  // decoded from the next state so they line up with the phase they mark.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt        <= '0;
      bus.PSEL        <= 1'b0;
      bus.PENABLE     <= 1'b0;
      bus.PADDR       <= {ADDR_W{1'b0}};
      bus.PWRITE      <= 1'b0;
      bus.PWDATA      <= {DATA_W{1'b0}};
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= {DATA_W{1'b0}};
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      bus.PSEL      <= (state_d != IDLE);
      bus.PENABLE   <= (state_d == ACCESS);
      bus.rsp_valid <= done | tmo;

      if (accept) begin
        bus.PADDR  <= bus.cmd_addr;
        bus.PWRITE <= bus.cmd_write;
        bus.PWDATA <= bus.cmd_write ? bus.cmd_wdata : {DATA_W{1'b0}};
        wait_cnt   <= '0;
      end else if ((state_q == ACCESS) && !bus.PREADY) begin
        wait_cnt   <= wait_cnt + CNT_W'(1);
      end

      if (done) begin
        bus.rsp_rdata   <= bus.PWRITE ? {DATA_W{1'b0}} : bus.PRDATA;
        bus.rsp_err     <= bus.PSLVERR;
        bus.rsp_timeout <= 1'b0;
      end else if (tmo) begin
        bus.rsp_rdata   <= {DATA_W{1'b0}};
        bus.rsp_err     <= 1'b1;
        bus.rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: scoreboard of expected responses,
// one task per scenario, inputs driven and outputs sampled on the falling edge.
module tb_apb_requester;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  logic PCLK;
  logic PRESET;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  apb_requester_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Drives one command and plays the completer; reports what it observed.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int ready_after, input logic [31:0] rdata,
                         input logic err_in, input logic err_out,
                         output logic rdy, output int acc, output int lat, output logic seen,
                         output logic stable, output logic proto, output rsp_t got);
    logic [31:0] exp_wd;
    exp_wd = wr ? wdata : 32'h0;
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = err_out;
    bus.PRDATA    = 32'hBAD0_BAD0;
    rdy    = bus.cmd_ready;
    acc    = 0;
    lat    = 0;
    seen   = 1'b0;
    stable = 1'b1;
    proto  = 1'b1;
    got    = '0;
    for (int c = 0; c < 64 && !seen; c++) begin
      @(negedge PCLK);
      lat++;
      bus.cmd_valid = 1'b0;
      if (bus.PENABLE && !bus.PSEL) proto = 1'b0;
      if (bus.rsp_valid) begin
        seen = 1'b1;
        got  = '{rdata: bus.rsp_rdata, err: bus.rsp_err, tmo: bus.rsp_timeout};
        if (bus.PSEL || bus.PENABLE) proto = 1'b0;
      end else if (bus.PSEL) begin
        if (bus.PADDR !== addr || bus.PWRITE !== wr || bus.PWDATA !== exp_wd) stable = 1'b0;
        if (bus.PENABLE) begin
          acc++;
          bus.PREADY  = (acc > ready_after);
          bus.PSLVERR = err_in;
          bus.PRDATA  = rdata;
        end else begin
          bus.PREADY  = 1'b1;
          bus.PSLVERR = err_out;
          bus.PRDATA  = 32'hBAD0_BAD0;
        end
      end else begin
        bus.PREADY  = 1'b1;
        bus.PSLVERR = err_out;
      end
    end
    bus.PSLVERR = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (2) @(negedge PCLK);
    n_checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout});
    end
    n_checks++;
    if (bus.PADDR !== 32'h0 || bus.PWDATA !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: PADDR %h PWDATA %h rsp_rdata %h expected all 0",
               bus.PADDR, bus.PWDATA, bus.rsp_rdata);
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", bus.cmd_ready);
    end
    PRESET = 1'b0;
  endtask

  task automatic test_write();
    logic rdy, seen, stable, proto;
    int   acc, lat;
    rsp_t got, exp;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
    do_xfer(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 0, 32'hFFFF_FFFF, 1'b0, 1'b0,
            rdy, acc, lat, seen, stable, proto, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL wr_ready: got %b expected 1", rdy); end
    n_checks++;
    if (seen !== 1'b1 || lat != 3) begin
      n_fail++; $display("FAIL wr_latency: seen %b latency %0d expected 1 / 3", seen, lat);
    end
    n_checks++;
    if (acc != 1) begin n_fail++; $display("FAIL wr_access_cycles: got %0d expected 1", acc); end
    n_checks++;
    if (stable !== 1'b1 || proto !== 1'b1) begin
      n_fail++; $display("FAIL wr_bus_stable: stable %b protocol %b expected 1 / 1", stable, proto);
    end
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL wr_rsp: got %h/%b/%b expected %h/%b/%b",
                         got.rdata, got.err, got.tmo, exp.rdata, exp.err, exp.tmo);
    end
    @(negedge PCLK);
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.PSEL !== 1'b0 || bus.PWDATA !== 32'hA5A5_5A5A) begin
      n_fail++; $display("FAIL wr_after: rsp_valid %b PSEL %b PWDATA %h expected 0 / 0 / a5a55a5a",
                         bus.rsp_valid, bus.PSEL, bus.PWDATA);
    end
  endtask

  task automatic test_read_wait();
    logic rdy, seen, stable, proto;
    int   acc, lat;
    rsp_t got, exp;
    exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0, tmo: 1'b0});
    do_xfer(1'b0, 32'h0000_0004, 32'hDEAD_BEEF, 2, 32'h1234_5678, 1'b0, 1'b0,
            rdy, acc, lat, seen, stable, proto, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (acc != 3 || lat != 5) begin
      n_fail++; $display("FAIL rd_wait_cycles: access %0d latency %0d expected 3 / 5", acc, lat);
    end
    n_checks++;
    if (stable !== 1'b1 || proto !== 1'b1) begin
      n_fail++; $display("FAIL rd_wait_stable: stable %b protocol %b expected 1 / 1", stable, proto);
    end
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL rd_wait_rsp: got %h/%b/%b expected %h/%b/%b",
                         got.rdata, got.err, got.tmo, exp.rdata, exp.err, exp.tmo);
    end
    @(negedge PCLK);
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL rd_rsp_hold: rsp_valid %b rsp_rdata %h expected 0 / 12345678",
                         bus.rsp_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_slverr();
    logic rdy, seen, stable, proto;
    int   acc, lat;
    rsp_t got, exp;
    exp_q.push_back('{rdata: 32'h5A5A_0001, err: 1'b1, tmo: 1'b0});
    do_xfer(1'b0, 32'h0000_0008, 32'h0, 0, 32'h5A5A_0001, 1'b1, 1'b1,
            rdy, acc, lat, seen, stable, proto, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (seen !== 1'b1 || got !== exp) begin
      n_fail++; $display("FAIL slverr_rsp: seen %b got %h/%b/%b expected %h/%b/%b",
                         seen, got.rdata, got.err, got.tmo, exp.rdata, exp.err, exp.tmo);
    end
    exp_q.push_back('{rdata: 32'h00C0_FFEE, err: 1'b0, tmo: 1'b0});
    do_xfer(1'b0, 32'h0000_000C, 32'h0, 0, 32'h00C0_FFEE, 1'b0, 1'b1,
            rdy, acc, lat, seen, stable, proto, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (seen !== 1'b1 || got !== exp) begin
      n_fail++; $display("FAIL slverr_outside: seen %b got %h/%b/%b expected %h/%b/%b",
                         seen, got.rdata, got.err, got.tmo, exp.rdata, exp.err, exp.tmo);
    end
  endtask

  task automatic test_timeout();
    logic rdy, seen, stable, proto;
    int   acc, lat;
    rsp_t got, exp;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1, tmo: 1'b1});
    do_xfer(1'b0, 32'h0000_0020, 32'h0, 1000, 32'h7777_7777, 1'b0, 1'b0,
            rdy, acc, lat, seen, stable, proto, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (seen !== 1'b1 || acc != 16 || lat != 18) begin
      n_fail++; $display("FAIL tmo_cycles: seen %b access %0d latency %0d expected 1 / 16 / 18",
                         seen, acc, lat);
    end
    n_checks++;
    if (proto !== 1'b1 || stable !== 1'b1) begin
      n_fail++; $display("FAIL tmo_bus: protocol %b stable %b expected 1 / 1", proto, stable);
    end
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL tmo_rsp: got %h/%b/%b expected %h/%b/%b",
                         got.rdata, got.err, got.tmo, exp.rdata, exp.err, exp.tmo);
    end
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
    do_xfer(1'b1, 32'h0000_0024, 32'h0BAD_F00D, 1, 32'h9999_9999, 1'b0, 1'b0,
            rdy, acc, lat, seen, stable, proto, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (seen !== 1'b1 || acc != 2 || lat != 4 || stable !== 1'b1 || got !== exp) begin
      n_fail++; $display("FAIL tmo_then_write: seen %b access %0d latency %0d stable %b rsp %h/%b/%b expected 1 / 2 / 4 / 1 / %h/%b/%b",
                         seen, acc, lat, stable, got.rdata, got.err, got.tmo, exp.rdata, exp.err, exp.tmo);
    end
  endtask

  task automatic test_back_to_back();
    int   idx = 0;
    int   n_acc = 0;
    int   n_rsp = 0;
    int   acc_cyc[4];
    int   rsp_cyc[4];
    int   proto_bad = 0;
    int   ready_bad = 0;
    int   gap_bad = 0;
    logic pending = 1'b0;
    rsp_t got, exp;
    logic [31:0] a;
    @(negedge PCLK);
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h100;
    bus.cmd_wdata = 32'h1111_1111;
    for (int cyc = 0; cyc < 40 && n_rsp < 4; cyc++) begin
      bus.PRDATA = {16'hC0DE, bus.PADDR[15:0]};
      if (bus.cmd_valid && bus.cmd_ready) begin
        a = 32'h100 + 32'(idx * 4);
        if (idx[0]) exp_q.push_back('{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
        else        exp_q.push_back('{rdata: {16'hC0DE, a[15:0]}, err: 1'b0, tmo: 1'b0});
        if (n_acc < 4) acc_cyc[n_acc] = cyc;
        n_acc++;
        pending = 1'b1;
      end
      @(negedge PCLK);
      if (bus.PENABLE && !bus.PSEL) proto_bad++;
      if (bus.cmd_ready !== !bus.PSEL) ready_bad++;
      if (bus.rsp_valid) begin
        got = '{rdata: bus.rsp_rdata, err: bus.rsp_err, tmo: bus.rsp_timeout};
        if (n_rsp < 4) rsp_cyc[n_rsp] = cyc + 1;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b2b_rsp_extra: got %h/%b/%b expected no response", got.rdata, got.err, got.tmo);
        end else begin
          exp = exp_q.pop_front();
          n_checks++;
          if (got !== exp) begin
            n_fail++; $display("FAIL b2b_rsp%0d: got %h/%b/%b expected %h/%b/%b",
                               n_rsp, got.rdata, got.err, got.tmo, exp.rdata, exp.err, exp.tmo);
          end
        end
        n_rsp++;
      end
      if (pending) begin
        pending = 1'b0;
        idx++;
        if (idx < 4) begin
          bus.cmd_write = idx[0];
          bus.cmd_addr  = 32'h100 + 32'(idx * 4);
          bus.cmd_wdata = 32'h1111_1111 * 32'(idx + 1);
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
    end
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (n_acc != 4 || n_rsp != 4) begin
      n_fail++; $display("FAIL b2b_count: accepts %0d responses %0d expected 4 / 4", n_acc, n_rsp);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (rsp_cyc[i] - acc_cyc[i] != 3) gap_bad++;
        if (i > 0 && acc_cyc[i] - acc_cyc[i-1] != 3) gap_bad++;
      end
      n_checks++;
      if (gap_bad != 0) begin
        n_fail++; $display("FAIL b2b_spacing: %0d bad gaps expected 0", gap_bad);
      end
    end
    n_checks++;
    if (proto_bad != 0 || ready_bad != 0) begin
      n_fail++; $display("FAIL b2b_protocol: penable_without_psel %0d ready_outside_idle %0d expected 0 / 0",
                         proto_bad, ready_bad);
    end
  endtask

  task automatic test_reset_mid();
    logic rdy, seen, stable, proto;
    int   acc, lat;
    int   rsp_seen = 0;
    logic in_access = 1'b0;
    rsp_t got, exp;
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h0000_0030;
    bus.cmd_wdata = 32'h3333_3333;
    bus.PREADY    = 1'b0;
    for (int c = 0; c < 10 && !in_access; c++) begin
      @(negedge PCLK);
      bus.cmd_valid = 1'b0;
      if (bus.PSEL && bus.PENABLE) in_access = 1'b1;
    end
    n_checks++;
    if (in_access !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_reach: access reached %b expected 1", in_access);
    end
    #1 PRESET = 1'b1;
    #1;
    n_checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid} !== 4'b0 ||
        bus.PADDR !== 32'h0 || bus.PWDATA !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_async: PSEL %b PENABLE %b PWRITE %b rsp_valid %b PADDR %h PWDATA %h expected all 0",
                         bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.PADDR, bus.PWDATA);
    end
    repeat (2) begin
      @(negedge PCLK);
      if (bus.rsp_valid) rsp_seen++;
    end
    PRESET     = 1'b0;
    bus.PREADY = 1'b1;
    @(negedge PCLK);
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", bus.cmd_ready);
    end
    repeat (3) begin
      if (bus.rsp_valid) rsp_seen++;
      @(negedge PCLK);
    end
    n_checks++;
    if (rsp_seen != 0) begin
      n_fail++; $display("FAIL rst_mid_no_rsp: responses %0d expected 0", rsp_seen);
    end
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
    do_xfer(1'b1, 32'h0000_0034, 32'h4444_4444, 0, 32'hFFFF_0000, 1'b0, 1'b0,
            rdy, acc, lat, seen, stable, proto, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (rdy !== 1'b1 || seen !== 1'b1 || lat != 3 || stable !== 1'b1 || got !== exp) begin
      n_fail++; $display("FAIL rst_mid_write: ready %b seen %b latency %0d stable %b rsp %h/%b/%b expected 1 / 1 / 3 / 1 / %h/%b/%b",
                         rdy, seen, lat, stable, got.rdata, got.err, got.tmo, exp.rdata, exp.err, exp.tmo);
    end
  endtask

  initial begin
    PRESET        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.PRDATA    = 32'h0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d expected responses left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
